// File: rtl/mlp_pkg.sv
// Shared widths and FSM state encoding for the MLP layer datapath.
package mlp_pkg;

  localparam int ACT_W = 16;
  localparam int W_W   = 8;
  localparam int B_W   = 8;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_index_counter.sv
// Nested neuron/input index counter: i runs fastest, j steps when i wraps.
// w_idx tracks j*N_IN+i incrementally so no multiplier is needed.
module seq_index_counter #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int AW    = 4,
  parameter int WAW   = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [AW-1:0]  i_idx,
  output logic [AW-1:0]  j_idx,
  output logic [WAW-1:0] w_idx,
  output logic           first,
  output logic           last_i,
  output logic           last
);

  localparam logic [AW-1:0] I_MAX = AW'(N_IN - 1);
  localparam logic [AW-1:0] J_MAX = AW'(N_OUT - 1);

  assign first  = (i_idx == '0);
  assign last_i = (i_idx == I_MAX);
  assign last   = last_i && (j_idx == J_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      i_idx <= '0;
      j_idx <= '0;
      w_idx <= '0;
    end else if (advance) begin
      if (last_i) begin
        i_idx <= '0;
        j_idx <= last ? '0 : j_idx + AW'(1);
      end else begin
        i_idx <= i_idx + AW'(1);
      end
      w_idx <= last ? '0 : w_idx + WAW'(1);
    end
  end

endmodule

// File: rtl/mac_layer_sequencer.sv
// Streams one fully-connected layer through a single external MAC: address
// issue, one-cycle RAM latency stage, then result write-back of the MAC output.
module mac_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int AW    = 4,
  parameter int WAW   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    act_addr,
  input  logic [ACT_W-1:0] act_rdata,
  output logic [WAW-1:0]   w_addr,
  input  logic [W_W-1:0]   w_rdata,
  output logic [AW-1:0]    b_addr,
  input  logic [B_W-1:0]   b_rdata,
  output logic             mac_clr,
  output logic [ACT_W-1:0] mac_op1,
  output logic [W_W-1:0]   mac_op2,
  output logic [B_W-1:0]   mac_bias,
  input  logic [ACC_W-1:0] mac_out,
  output logic             res_we,
  output logic [AW-1:0]    res_addr,
  output logic [ACC_W-1:0] res_data
);

  seq_state_e state, state_next;

  logic           run, idle;
  logic [AW-1:0]  i_idx, j_idx;
  logic [WAW-1:0] w_idx;
  logic           cnt_first, cnt_last_i, cnt_last;

  // Stage 1: operands returning from the RAMs; stage 2: write-back.
  logic           s1_valid, s1_first, s1_last_i, s1_final;
  logic [AW-1:0]  s1_j;
  logic           s2_we, s2_final;
  logic [AW-1:0]  s2_j;
  logic [B_W-1:0] bias_q;

  // NOTE: reset here is synchronous, so it only appears inside the clocked
  // branch and never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    idle       = 1'b0;
    run        = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        idle = 1'b1;
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
        if (cnt_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (s2_final) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  seq_index_counter #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .AW   (AW),
    .WAW  (WAW)
  ) u_index (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle),
    .advance(run),
    .i_idx  (i_idx),
    .j_idx  (j_idx),
    .w_idx  (w_idx),
    .first  (cnt_first),
    .last_i (cnt_last_i),
    .last   (cnt_last)
  );

  assign act_addr = i_idx;
  assign w_addr   = w_idx;
  assign b_addr   = j_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last_i <= 1'b0;
      s1_final  <= 1'b0;
      s1_j      <= '0;
      s2_we     <= 1'b0;
      s2_final  <= 1'b0;
      s2_j      <= '0;
      bias_q    <= '0;
      done      <= 1'b0;
    end else begin
      s1_valid  <= run;
      s1_first  <= run && cnt_first;
      s1_last_i <= run && cnt_last_i;
      s1_final  <= run && cnt_last;
      s1_j      <= j_idx;
      s2_we     <= s1_valid && s1_last_i;
      s2_final  <= s1_valid && s1_final;
      s2_j      <= s1_j;
      if (s1_valid && s1_first) bias_q <= b_rdata;
      done      <= (state == ST_DRAIN) && s2_final;
    end
  end

  // Idle operands are zero with clr low, so the MAC sum simply holds.
  always_comb begin
    mac_clr  = s1_valid && s1_first;
    mac_op1  = s1_valid ? act_rdata : '0;
    mac_op2  = s1_valid ? w_rdata   : '0;
    // The first pair must use the fresh bias so single-input neurons are right.
    mac_bias = mac_clr ? b_rdata : bias_q;
  end

  assign res_we   = s2_we;
  assign res_addr = s2_j;
  assign res_data = mac_out;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench: two sequencer instances (4x2 and 1x3) with RAM and MAC models,
// scoreboard of expected result writes, and per-cycle busy/done checks.
module tb_mac_layer_sequencer;

  logic clk, reset, start, sel;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  // Instance A: N_IN=4, N_OUT=2
  logic        a_start, a_busy, a_done, a_mac_clr, a_res_we;
  logic [3:0]  a_act_addr, a_b_addr, a_res_addr;
  logic [6:0]  a_w_addr;
  logic [15:0] a_act_rdata, a_mac_op1, a_mac_out, a_res_data;
  logic [7:0]  a_w_rdata, a_b_rdata, a_mac_op2, a_mac_bias;
  logic [15:0] a_sum;
  logic [15:0] a_act_mem [16];
  logic [7:0]  a_w_mem   [128];
  logic [7:0]  a_b_mem   [16];

  // Instance B: N_IN=1, N_OUT=3
  logic        b_start, b_busy, b_done, b_mac_clr, b_res_we;
  logic [3:0]  b_act_addr, b_b_addr, b_res_addr, b_w_addr;
  logic [15:0] b_act_rdata, b_mac_op1, b_mac_out, b_res_data;
  logic [7:0]  b_w_rdata, b_b_rdata, b_mac_op2, b_mac_bias;
  logic [15:0] b_sum;
  logic [15:0] b_act_mem [16];
  logic [7:0]  b_w_mem   [16];
  logic [7:0]  b_b_mem   [16];

  logic        obs_busy, obs_done, obs_we;
  logic [3:0]  obs_addr;
  logic [15:0] obs_data;

  assign a_start  = start && !sel;
  assign b_start  = start && sel;
  assign obs_busy = sel ? b_busy : a_busy;
  assign obs_done = sel ? b_done : a_done;
  assign obs_we   = sel ? b_res_we : a_res_we;
  assign obs_addr = sel ? b_res_addr : a_res_addr;
  assign obs_data = sel ? b_res_data : a_res_data;

  mac_layer_sequencer #(.N_IN(4), .N_OUT(2), .AW(4), .WAW(7)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .act_addr(a_act_addr), .act_rdata(a_act_rdata), .w_addr(a_w_addr), .w_rdata(a_w_rdata),
    .b_addr(a_b_addr), .b_rdata(a_b_rdata), .mac_clr(a_mac_clr), .mac_op1(a_mac_op1),
    .mac_op2(a_mac_op2), .mac_bias(a_mac_bias), .mac_out(a_mac_out), .res_we(a_res_we),
    .res_addr(a_res_addr), .res_data(a_res_data)
  );

  mac_layer_sequencer #(.N_IN(1), .N_OUT(3), .AW(4), .WAW(4)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .act_addr(b_act_addr), .act_rdata(b_act_rdata), .w_addr(b_w_addr), .w_rdata(b_w_rdata),
    .b_addr(b_b_addr), .b_rdata(b_b_rdata), .mac_clr(b_mac_clr), .mac_op1(b_mac_op1),
    .mac_op2(b_mac_op2), .mac_bias(b_mac_bias), .mac_out(b_mac_out), .res_we(b_res_we),
    .res_addr(b_res_addr), .res_data(b_res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC: new sum registered; out registers that new sum plus the bias, 16-bit wrap.
  function automatic logic [15:0] mac_sum(input logic clr, input logic [15:0] sum,
                                          input logic [15:0] op1, input logic [7:0] op2);
    return 16'((clr ? 0 : int'($signed(sum))) + int'($signed(op1)) * int'($signed(op2)));
  endfunction

  function automatic logic [15:0] mac_res(input logic [15:0] s, input logic [7:0] bias);
    return 16'(int'($signed(s)) + int'($signed(bias)));
  endfunction

  always @(posedge clk) begin
    a_act_rdata <= a_act_mem[a_act_addr];
    a_w_rdata   <= a_w_mem[a_w_addr];
    a_b_rdata   <= a_b_mem[a_b_addr];
    a_sum       <= mac_sum(a_mac_clr, a_sum, a_mac_op1, a_mac_op2);
    a_mac_out   <= mac_res(mac_sum(a_mac_clr, a_sum, a_mac_op1, a_mac_op2), a_mac_bias);
    b_act_rdata <= b_act_mem[b_act_addr];
    b_w_rdata   <= b_w_mem[b_w_addr];
    b_b_rdata   <= b_b_mem[b_b_addr];
    b_sum       <= mac_sum(b_mac_clr, b_sum, b_mac_op1, b_mac_op2);
    b_mac_out   <= mac_res(mac_sum(b_mac_clr, b_sum, b_mac_op1, b_mac_op2), b_mac_bias);
  end

  // Whole-neuron reference: dot product plus bias, truncated to 16 bits.
  function automatic logic [15:0] ref_result(input bit s, input int j);
    int acc = 0;
    int nin = s ? 1 : 4;
    for (int i = 0; i < nin; i++)
      acc += s ? int'($signed(b_act_mem[i])) * int'($signed(b_w_mem[j*nin+i]))
               : int'($signed(a_act_mem[i])) * int'($signed(a_w_mem[j*nin+i]));
    acc += s ? int'($signed(b_b_mem[j])) : int'($signed(a_b_mem[j]));
    return 16'(acc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one layer; poke re-pulses start at that cycle, abort_at asserts reset
  // in that cycle, chain_out starts the next run in the done cycle.
  task automatic run_layer(input bit s, input int poke, input int abort_at,
                           input bit chain_in, input bit chain_out);
    int   nin, nout, k;
    bit   aborted;
    exp_t e;
    nin  = s ? 1 : 4;
    nout = s ? 3 : 2;
    k    = nin * nout;
    sel  = s;
    if (!chain_in) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    for (int j = 0; j < nout; j++)
      sb.push_back('{cyc: (j+1)*nin + 2, addr: 4'(j), data: ref_result(s, j)});
    for (int rel = chain_in ? 1 : 0; rel <= k + 3; rel++) begin
      @(negedge clk);
      aborted = (abort_at > 0) && (rel > abort_at);
      check($sformatf("busy@%0d", rel), 32'(obs_busy),
            32'(!aborted && rel >= 1 && rel <= k + 2));
      check($sformatf("done@%0d", rel), 32'(obs_done), 32'(!aborted && rel == k + 3));
      if (obs_we) begin
        if (sb.size() == 0) begin
          check($sformatf("spurious_we@%0d", rel), 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("res_cycle", 32'(rel), 32'(e.cyc));
          check("res_addr", 32'(obs_addr), 32'(e.addr));
          check("res_data", 32'(obs_data), 32'(e.data));
        end
      end
      @(posedge clk); #1;
      start = ((rel + 1) == poke) || (chain_out && (rel + 1) == k + 3);
      reset = (abort_at > 0) && ((rel + 1) == abort_at);
    end
    if (abort_at > 0) sb.delete();
    else check("writes_left", 32'(sb.size()), 32'(0));
  endtask

  task automatic load_test1();
    for (int i = 0; i < 4; i++) a_act_mem[i] = 16'(i + 1);
    for (int i = 0; i < 8; i++) a_w_mem[i] = 8'd1;
    a_b_mem[0] = 8'sd5;
    a_b_mem[1] = -8'sd3;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_act_mem[i] = '0; a_b_mem[i] = '0;
      b_act_mem[i] = '0; b_w_mem[i] = '0; b_b_mem[i] = '0;
    end
    for (int i = 0; i < 128; i++) a_w_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(a_busy), 32'(0));
    check("rst_done", 32'(a_done), 32'(0));
    check("rst_we", 32'(a_res_we), 32'(0));
    check("rst_clr", 32'(a_mac_clr), 32'(0));
    check("rst_op1", 32'(a_mac_op1), 32'(0));
    check("rst_op2", 32'(a_mac_op2), 32'(0));
    check("rst_bias", 32'(a_mac_bias), 32'(0));
    check("rst_act_addr", 32'(a_act_addr), 32'(0));
    check("rst_w_addr", 32'(a_w_addr), 32'(0));
    check("rst_b_addr", 32'(a_b_addr), 32'(0));

    // Basic layer: results 15 @0 (cycle 6) and 7 @1 (cycle 10), done at 11.
    load_test1();
    check("ref_n0", 32'(ref_result(1'b0, 0)), 32'(16'd15));
    check("ref_n1", 32'(ref_result(1'b0, 1)), 32'(16'd7));
    run_layer(1'b0, 0, 0, 1'b0, 1'b0);

    // Start re-pulsed mid-run is ignored.
    run_layer(1'b0, 3, 0, 1'b0, 1'b0);

    // Reset during cycle 5 aborts the run; a fresh run still gives 15, 7.
    run_layer(1'b0, 0, 5, 1'b0, 1'b0);
    run_layer(1'b0, 0, 0, 1'b0, 1'b0);

    // Back-to-back: second start lands in the done cycle.
    run_layer(1'b0, 0, 0, 1'b0, 1'b1);
    run_layer(1'b0, 0, 0, 1'b1, 1'b0);

    // Wrap: 4 * 100 * 127 = 50800 -> 0xC670 (-14736).
    for (int i = 0; i < 4; i++) a_act_mem[i] = 16'd100;
    for (int i = 0; i < 8; i++) a_w_mem[i] = 8'd127;
    a_b_mem[0] = 8'd0;
    a_b_mem[1] = 8'd0;
    check("ref_wrap", 32'(ref_result(1'b0, 0)), 32'(16'hC670));
    run_layer(1'b0, 0, 0, 1'b0, 1'b0);

    // Single-input neurons: 7, -7, 11 on consecutive cycles.
    b_act_mem[0] = 16'd2;
    b_w_mem[0]   = 8'sd3;
    b_w_mem[1]   = -8'sd4;
    b_w_mem[2]   = 8'sd5;
    for (int j = 0; j < 3; j++) b_b_mem[j] = 8'sd1;
    check("ref_b1", 32'(ref_result(1'b1, 1)), 32'(16'hFFF9));
    run_layer(1'b1, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
